// File: rtl/hack_dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// hack_dmem_responder_pkg
//   Shared definitions for the Hack data-memory responder: memory-map
//   constants, region and keyboard-hold state encodings, and the address
//   decoder used by the top module.
//   No ports (package).
// -----------------------------------------------------------------------------
package hack_dmem_responder_pkg;

   // Hack memory map (15-bit word addresses)
   localparam logic [14:0] SCREEN_BASE  = 15'h4000;
   localparam logic [14:0] KBD_ADDR     = 15'h6000;
   localparam int unsigned SCREEN_WORDS = 8192;
   localparam int unsigned RAM_WORDS    = 16384;
   localparam int unsigned SCR_OFF_W    = 13;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_SCREEN,
      REGION_KBD,
      REGION_NONE
   } region_e;

   // HOLD: counting towards saturation; ARMED: saturated, next event may load.
   typedef enum logic {
      KBD_HOLD,
      KBD_ARMED
   } kbd_state_e;

   function automatic region_e decode_region(input logic [14:0] addr);
      if (addr < SCREEN_BASE) begin
         return REGION_RAM;
      end else if (addr < KBD_ADDR) begin
         return REGION_SCREEN;
      end else if (addr == KBD_ADDR) begin
         return REGION_KBD;
      end else begin
         return REGION_NONE;
      end
   endfunction

endpackage

// File: rtl/hack_dmem_responder_fifo.sv
// -----------------------------------------------------------------------------
// hack_sync_fifo
//   Single-clock FIFO with first-word-fall-through head. A push while full is
//   accepted only when a pop happens in the same cycle (the slot being freed
//   is the one written). Storage is not reset; only the pointers are.
// Ports
//   clk      in   1      clock, rising edge
//   reset_n  in   1      synchronous active-low reset, empties the queue
//   push     in   1      write request
//   pop      in   1      read request (ignored when empty)
//   wdata    in   WIDTH  data written on an accepted push
//   full     out  1      DEPTH entries held
//   empty    out  1      no entries held
//   head     out  WIDTH  oldest entry (valid when !empty)
// -----------------------------------------------------------------------------
module hack_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   // DEPTH is a power of two (>= 2); pointers carry one wrap bit.
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[PTR_W-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/hack_dmem_responder.sv
// -----------------------------------------------------------------------------
// hack_dmem_responder
//   Responder end of the hackcore data-memory port. Decodes the Hack memory
//   map (RAM 0x0000-0x3FFF, screen 0x4000-0x5FFF, keyboard 0x6000), keeps a
//   shadow copy of the screen and streams every screen write to an external
//   framebuffer, and presents buffered keyboard events in KBD with a minimum
//   visibility time per code.
//   Optional macro HACK_DMEM_OOR_TRAP_EN adds a sticky trap on the first
//   write at or above 0x6000 (oor_err_o / oor_addr_o).
// Ports
//   clk_i        in   1       clock, rising edge
//   reset_i      in   1       synchronous active-low reset
//   load_i       in   1       write strobe from core
//   addr_i       in   ADDR_W  word address from core
//   data_i       in   DATA_W  write data from core
//   data_o       out  DATA_W  read data, combinational on addr_i
//   kbd_valid_i  in   1       keyboard event valid
//   kbd_code_i   in   DATA_W  key code (0 = all released)
//   kbd_ready_o  out  1       keyboard queue not full
//   fb_valid_o   out  1       framebuffer write available
//   fb_addr_o    out  13      screen word offset
//   fb_data_o    out  DATA_W  screen word value
//   fb_ready_i   in   1       framebuffer consumer accepts
//   fb_ovf_o     out  1       sticky: screen write dropped (queue full)
//   oor_err_o    out  1       (trap build) sticky out-of-range write seen
//   oor_addr_o   out  ADDR_W  (trap build) address of first such write
// -----------------------------------------------------------------------------
module hack_dmem_responder
   import hack_dmem_responder_pkg::*;
#(
   parameter int unsigned DATA_W          = 16,
   parameter int unsigned ADDR_W          = 15,
   parameter int unsigned SCR_FIFO_DEPTH  = 8,
   parameter int unsigned KBD_FIFO_DEPTH  = 4,
   parameter int unsigned KBD_HOLD_CYCLES = 1024
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 load_i,
   input  logic [ADDR_W-1:0]    addr_i,
   input  logic [DATA_W-1:0]    data_i,
   output logic [DATA_W-1:0]    data_o,
   input  logic                 kbd_valid_i,
   input  logic [DATA_W-1:0]    kbd_code_i,
   output logic                 kbd_ready_o,
   output logic                 fb_valid_o,
   output logic [SCR_OFF_W-1:0] fb_addr_o,
   output logic [DATA_W-1:0]    fb_data_o,
   input  logic                 fb_ready_i,
   output logic                 fb_ovf_o
`ifdef HACK_DMEM_OOR_TRAP_EN
   ,
   output logic                 oor_err_o,
   output logic [ADDR_W-1:0]    oor_addr_o
`endif
);

   localparam int unsigned HOLD_MAX = KBD_HOLD_CYCLES - 1;
   localparam int unsigned CNT_W    = (KBD_HOLD_CYCLES > 1) ? $clog2(KBD_HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   // With a one-cycle hold the counter is saturated straight out of reset.
   localparam kbd_state_e KBD_START = (HOLD_MAX == 0) ? KBD_ARMED : KBD_HOLD;

   logic [14:0]   addr15;
   region_e       region;

   logic [DATA_W-1:0] ram    [RAM_WORDS];
   logic [DATA_W-1:0] shadow [SCREEN_WORDS];

   logic                        scr_push;
   logic                        scr_pop;
   logic                        scr_full;
   logic                        scr_empty;
   logic [SCR_OFF_W+DATA_W-1:0] scr_head;

   logic              kbd_push;
   logic              kbd_pop;
   logic              kbd_full;
   logic              kbd_empty;
   logic [DATA_W-1:0] kbd_head;

   kbd_state_e        kbd_state;
   logic [CNT_W-1:0]  hold_cnt;
   logic [CNT_W-1:0]  hold_cnt_next;
   logic [DATA_W-1:0] kbd_reg;
   logic              ovf_q;

   assign addr15 = 15'(addr_i);
   assign region = decode_region(addr15);

   // Memory stores: written at the edge, read back combinationally.
   always_ff @(posedge clk_i) begin
      if (load_i && (region == REGION_RAM)) begin
         ram[addr15[13:0]] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (load_i && (region == REGION_SCREEN)) begin
         shadow[addr15[12:0]] <= data_i;
      end
   end

   always_comb begin
      data_o = '0;
      unique case (region)
         REGION_RAM:    data_o = ram[addr15[13:0]];
         REGION_SCREEN: data_o = shadow[addr15[12:0]];
         REGION_KBD:    data_o = kbd_reg;
         default:       data_o = '0;
      endcase
   end

   // Screen write queue. The base is 8K-aligned, so the offset is the low bits.
   assign scr_push = load_i && (region == REGION_SCREEN);
   assign scr_pop  = fb_valid_o && fb_ready_i;

   hack_sync_fifo #(
      .WIDTH (SCR_OFF_W + DATA_W),
      .DEPTH (SCR_FIFO_DEPTH)
   ) u_scr_fifo (
      .clk     (clk_i),
      .reset_n (reset_i),
      .push    (scr_push),
      .pop     (scr_pop),
      .wdata   ({addr15[12:0], data_i}),
      .full    (scr_full),
      .empty   (scr_empty),
      .head    (scr_head)
   );

   assign fb_valid_o = !scr_empty;
   assign fb_addr_o  = scr_head[SCR_OFF_W+DATA_W-1:DATA_W];
   assign fb_data_o  = scr_head[DATA_W-1:0];
   assign fb_ovf_o   = ovf_q;

   // A write that finds the queue full and not draining this cycle is lost.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         ovf_q <= 1'b0;
      end else if (scr_push && scr_full && !scr_pop) begin
         ovf_q <= 1'b1;
      end
   end

   // Keyboard event queue
   assign kbd_ready_o = !kbd_full;
   assign kbd_push    = kbd_valid_i && kbd_ready_o;
   assign kbd_pop     = (kbd_state == KBD_ARMED) && !kbd_empty;

   hack_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (KBD_FIFO_DEPTH)
   ) u_kbd_fifo (
      .clk     (clk_i),
      .reset_n (reset_i),
      .push    (kbd_push),
      .pop     (kbd_pop),
      .wdata   (kbd_code_i),
      .full    (kbd_full),
      .empty   (kbd_empty),
      .head    (kbd_head)
   );

   // KBD hold FSM: a newly loaded code stays for KBD_HOLD_CYCLES cycles at
   // least; once saturated the last code is kept until another event exists.
   assign hold_cnt_next = hold_cnt + CNT_ONE;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         kbd_state <= KBD_START;
         hold_cnt  <= '0;
         kbd_reg   <= '0;
      end else begin
         unique case (kbd_state)
            KBD_HOLD: begin
               hold_cnt <= hold_cnt_next;
               if (hold_cnt_next == CNT_LAST) begin
                  kbd_state <= KBD_ARMED;
               end
            end
            KBD_ARMED: begin
               if (!kbd_empty) begin
                  kbd_reg   <= kbd_head;
                  hold_cnt  <= '0;
                  kbd_state <= KBD_START;
               end
            end
            default: begin
               kbd_state <= KBD_START;
               hold_cnt  <= '0;
            end
         endcase
      end
   end

`ifdef HACK_DMEM_OOR_TRAP_EN
   // Only the first out-of-range write is captured.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         oor_err_o  <= 1'b0;
         oor_addr_o <= '0;
      end else if (load_i && (addr15 >= KBD_ADDR) && !oor_err_o) begin
         oor_err_o  <= 1'b1;
         oor_addr_o <= addr_i;
      end
   end
`endif

endmodule

// File: tb/tb_hack_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_hack_dmem_responder
//   Directed and randomized bench for hack_dmem_responder (KBD_HOLD_CYCLES=4).
//   A queue/array reference model predicts every observable output each cycle.
// -----------------------------------------------------------------------------
module tb_hack_dmem_responder;

   localparam int DW    = 16;
   localparam int AW    = 15;
   localparam int SCR_D = 8;
   localparam int KBD_D = 4;
   localparam int HOLD  = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          load;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          kbd_valid;
   logic [DW-1:0] kbd_code;
   logic          kbd_ready;
   logic          fb_valid;
   logic [12:0]   fb_addr;
   logic [DW-1:0] fb_data;
   logic          fb_ready;
   logic          fb_ovf;
`ifdef HACK_DMEM_OOR_TRAP_EN
   logic          oor_err;
   logic [AW-1:0] oor_addr;
`endif

   always #5 clk = ~clk;

   hack_dmem_responder #(
      .DATA_W          (DW),
      .ADDR_W          (AW),
      .SCR_FIFO_DEPTH  (SCR_D),
      .KBD_FIFO_DEPTH  (KBD_D),
      .KBD_HOLD_CYCLES (HOLD)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset_n),
      .load_i      (load),
      .addr_i      (addr),
      .data_i      (wdata),
      .data_o      (rdata),
      .kbd_valid_i (kbd_valid),
      .kbd_code_i  (kbd_code),
      .kbd_ready_o (kbd_ready),
      .fb_valid_o  (fb_valid),
      .fb_addr_o   (fb_addr),
      .fb_data_o   (fb_data),
      .fb_ready_i  (fb_ready),
      .fb_ovf_o    (fb_ovf)
`ifdef HACK_DMEM_OOR_TRAP_EN
      ,
      .oor_err_o   (oor_err),
      .oor_addr_o  (oor_addr)
`endif
   );

   // Reference model state
   logic [DW-1:0] ram_m [16384];
   bit            ram_k [16384];
   logic [DW-1:0] scr_m [8192];
   bit            scr_k [8192];
   logic [28:0]   fbq [$];
   logic [DW-1:0] kbq [$];
   logic [DW-1:0] kbd_m;
   int            last_chg;
   int            cyc;
   bit            ovf_m;
   bit            kb_acc;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, output bit known);
      known = 1'b1;
      if (a < 15'h4000) begin
         known = ram_k[a[13:0]];
         return ram_m[a[13:0]];
      end else if (a < 15'h6000) begin
         known = scr_k[a[12:0]];
         return scr_m[a[12:0]];
      end else if (a == 15'h6000) begin
         return kbd_m;
      end
      return '0;
   endfunction

   // Applies one rising edge to the model, using the inputs presented at it.
   task automatic model_edge();
      int fb_n = fbq.size();
      int kb_n = kbq.size();
      bit fb_pop;
      kb_acc = 1'b0;
      if (!reset_n) begin
         fbq.delete();
         kbq.delete();
         kbd_m    = '0;
         last_chg = cyc;
         ovf_m    = 1'b0;
      end else begin
         // a code may be replaced once it has been visible HOLD cycles
         if (kb_n > 0 && (cyc - last_chg) >= HOLD) begin
            kbd_m    = kbq.pop_front();
            last_chg = cyc;
         end
         if (kbd_valid && kb_n < KBD_D) begin
            kbq.push_back(kbd_code);
            kb_acc = 1'b1;
         end
         fb_pop = (fb_n > 0) && fb_ready;
         if (fb_pop) void'(fbq.pop_front());
         if (load && addr >= 15'h4000 && addr < 15'h6000) begin
            if (fb_n < SCR_D || fb_pop) fbq.push_back({addr[12:0], wdata});
            else ovf_m = 1'b1;
         end
      end
      if (load && addr < 15'h4000) begin
         ram_m[addr[13:0]] = wdata;
         ram_k[addr[13:0]] = 1'b1;
      end else if (load && addr < 15'h6000) begin
         scr_m[addr[12:0]] = wdata;
         scr_k[addr[12:0]] = 1'b1;
      end
      cyc++;
   endtask

   task automatic check_all();
      bit            known;
      logic [DW-1:0] exp_rd;
      exp_rd = model_read(addr, known);
      if (known) chk("data_o", 32'(rdata), 32'(exp_rd));
      chk("fb_valid", 32'(fb_valid), 32'(fbq.size() > 0));
      if (fbq.size() > 0) begin
         chk("fb_addr", 32'(fb_addr), 32'(fbq[0][28:16]));
         chk("fb_data", 32'(fb_data), 32'(fbq[0][15:0]));
      end
      chk("fb_ovf", 32'(fb_ovf), 32'(ovf_m));
      chk("kbd_ready", 32'(kbd_ready), 32'(kbq.size() < KBD_D));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      int n41;
      int r;
      reset_n   = 1'b0;
      load      = 1'b0;
      addr      = '0;
      wdata     = '0;
      kbd_valid = 1'b0;
      kbd_code  = '0;
      fb_ready  = 1'b0;
      cyc       = 0;
      last_chg  = 0;
      kbd_m     = '0;
      ovf_m     = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_fb_valid", 32'(fb_valid), 32'd0);
      chk("rst_fb_ovf", 32'(fb_ovf), 32'd0);
      addr = 15'h6000;
      #1;
      chk("rst_kbd", 32'(rdata), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("rst_kbd_ready", 32'(kbd_ready), 32'd1);

      // RAM write then read back; unmapped read
      load = 1'b1; addr = 15'h0010; wdata = 16'h1234;
      tick();
      load = 1'b0;
      #1;
      chk("ram_0010", 32'(rdata), 32'h1234);
      addr = 15'h7000;
      #1;
      chk("rd_7000", 32'(rdata), 32'd0);

      // single screen write streamed out
      fb_ready = 1'b1;
      load = 1'b1; addr = 15'h4005; wdata = 16'hFFFF;
      tick();
      load = 1'b0;
      chk("fb1_valid", 32'(fb_valid), 32'd1);
      chk("fb1_addr", 32'(fb_addr), 32'h005);
      chk("fb1_data", 32'(fb_data), 32'hFFFF);
      tick();
      chk("fb1_drained", 32'(fb_valid), 32'd0);
      addr = 15'h4005;
      #1;
      chk("shadow_4005", 32'(rdata), 32'hFFFF);

      // overflow: nine writes into an eight-entry stalled queue
      fb_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         load = 1'b1; addr = 15'(15'h4100 + i); wdata = 16'(16'hA000 + i);
         tick();
      end
      load = 1'b0;
      chk("ovf_set", 32'(fb_ovf), 32'd1);
      fb_ready = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_valid", 32'(fb_valid), 32'd1);
         chk("drain_addr", 32'(fb_addr), 32'(13'h100 + i));
         chk("drain_data", 32'(fb_data), 32'(16'hA000 + i));
         tick();
      end
      chk("drain_empty", 32'(fb_valid), 32'd0);
      addr = 15'h4108;
      #1;
      chk("shadow_lost_entry", 32'(rdata), 32'hA008);

      // keyboard: two back-to-back events with a saturated hold counter
      addr = 15'h6000;
      kbd_valid = 1'b1; kbd_code = 16'h0041;
      tick();
      kbd_code = 16'h0042;
      tick();
      kbd_valid = 1'b0;
      n41 = 0;
      for (int i = 0; i < 20 && rdata === 16'h0041; i++) begin
         n41++;
         tick();
      end
      chk("kbd_hold_len", 32'(n41), 32'(HOLD));
      chk("kbd_second", 32'(rdata), 32'h0042);
      for (int i = 0; i < 10; i++) tick();
      chk("kbd_kept", 32'(rdata), 32'h0042);

      // reset with queued screen writes (overflow flag is still set)
      fb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load = 1'b1; addr = 15'(15'h4200 + i); wdata = 16'(16'h5500 + i);
         tick();
      end
      load = 1'b0;
      chk("pre_rst_valid", 32'(fb_valid), 32'd1);
      addr = 15'h6000;
      reset_n = 1'b0;
      tick();
      chk("mid_rst_valid", 32'(fb_valid), 32'd0);
      chk("mid_rst_ovf", 32'(fb_ovf), 32'd0);
      chk("mid_rst_kbd", 32'(rdata), 32'd0);
      reset_n = 1'b1;
      tick();
      addr = 15'h0010;
      #1;
      chk("ram_survives_rst", 32'(rdata), 32'h1234);

`ifdef HACK_DMEM_OOR_TRAP_EN
      chk("oor_clear", 32'(oor_err), 32'd0);
      load = 1'b1; addr = 15'h6001; wdata = 16'h1111;
      tick();
      addr = 15'h7FFF;
      tick();
      load = 1'b0;
      chk("oor_err", 32'(oor_err), 32'd1);
      chk("oor_addr", 32'(oor_addr), 32'h6001);
`endif

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 9);
         if (r < 4)       addr = 15'($urandom_range(0, 31));
         else if (r < 6)  addr = 15'(15'h4000 + $urandom_range(0, 31));
         else if (r == 6) addr = 15'h5FFF;
         else if (r < 9)  addr = 15'h6000;
         else             addr = 15'($urandom_range(16'h6001, 16'h7FFF));
         load  = ($urandom_range(0, 2) == 0);
         wdata = 16'($urandom);
         if (n < 1500) fb_ready = ($urandom_range(0, 7) == 0);
         else          fb_ready = ($urandom_range(0, 3) != 0);
         // an event not yet accepted is held unchanged
         if (!kbd_valid || kb_acc) begin
            kbd_valid = ($urandom_range(0, 2) == 0);
            kbd_code  = 16'($urandom);
         end
         reset_n = ($urandom_range(0, 499) != 0);
         if (!reset_n) load = 1'b0;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
